// File: rtl/sram_rmw_ctrl.sv
// Single-port SRAM controller with byte-enable writes done as read-modify-write.
// Optional power-up zeroing sweep compiled in with `define SRAM_RMW_INIT_EN.
module sram_rmw_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 256,
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BE_WIDTH-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic                  init_done_o
);

`ifdef SRAM_RMW_INIT_EN
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4
    } state_t;
`endif

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] m;
        m = old_word;
        for (int k = 0; k < BE_WIDTH; k++) begin
            if (be[k]) begin
                m[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                m[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return m;
    endfunction

    state_t                state_r, state_s;
    logic                  req_we_r;
    logic [ADDR_WIDTH-1:0] req_addr_r;
    logic [DATA_WIDTH-1:0] req_wdata_r;
    logic [BE_WIDTH-1:0]   req_be_r;
    logic                  ready_r, ready_s;
    logic                  rsp_valid_r, rsp_valid_s;
    logic                  rsp_rd_r, rsp_rd_s;
    logic                  sram_req_r, sram_req_s;
    logic                  sram_we_r, sram_we_s;
    logic [ADDR_WIDTH-1:0] sram_addr_r, sram_addr_s;
    logic [DATA_WIDTH-1:0] sram_wdata_r, sram_wdata_s;
    logic                  init_done_s;
    logic                  accept_s;

`ifdef SRAM_RMW_INIT_EN
    logic                  init_done_r;
    logic [ADDR_WIDTH:0]   init_cnt_r, init_cnt_s;
`endif

    assign accept_s = req_valid_i && ready_r;

    // Next-state and next-output decode; every SRAM command is registered below.
    always_comb begin
        state_s      = state_r;
        sram_req_s   = 1'b0;
        sram_we_s    = 1'b0;
        sram_addr_s  = sram_addr_r;
        sram_wdata_s = sram_wdata_r;
        rsp_valid_s  = 1'b0;
        rsp_rd_s     = 1'b0;
`ifdef SRAM_RMW_INIT_EN
        init_done_s  = init_done_r;
        init_cnt_s   = init_cnt_r;
`else
        init_done_s  = 1'b1;
`endif
        case (state_r)
`ifdef SRAM_RMW_INIT_EN
            ST_INIT: begin
                if (init_cnt_r == (ADDR_WIDTH+1)'(NUM_WORDS)) begin
                    state_s     = ST_IDLE;
                    init_done_s = 1'b1;
                end else begin
                    sram_req_s   = 1'b1;
                    sram_we_s    = 1'b1;
                    sram_addr_s  = init_cnt_r[ADDR_WIDTH-1:0];
                    sram_wdata_s = {DATA_WIDTH{1'b0}};
                    init_cnt_s   = init_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                end
            end
`endif
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_we_i && (&req_be_i)) begin
                        state_s      = ST_WR;
                        sram_req_s   = 1'b1;
                        sram_we_s    = 1'b1;
                        sram_addr_s  = req_addr_i;
                        sram_wdata_s = req_wdata_i;
                        rsp_valid_s  = 1'b1;
                    end else if (req_we_i && !(|req_be_i)) begin
                        // Nothing to store: complete without touching the SRAM.
                        state_s     = ST_WR;
                        rsp_valid_s = 1'b1;
                    end else begin
                        state_s     = ST_RD;
                        sram_req_s  = 1'b1;
                        sram_addr_s = req_addr_i;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (req_we_r) begin
                    state_s = ST_MERGE;
                end else begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b1;
                    rsp_rd_s    = 1'b1;
                end
            end
            ST_MERGE: begin
                // Old word is on sram_rdata_i this cycle; merge straight into the write.
                state_s      = ST_WR;
                sram_req_s   = 1'b1;
                sram_we_s    = 1'b1;
                sram_addr_s  = req_addr_r;
                sram_wdata_s = merge_bytes(req_wdata_r, sram_rdata_i, req_be_r);
                rsp_valid_s  = 1'b1;
            end
            ST_WR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        ready_s = (state_s == ST_IDLE) && init_done_s && !rsp_valid_s;
    end

    // State, output and captured-request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef SRAM_RMW_INIT_EN
            state_r     <= ST_INIT;
            init_done_r <= 1'b0;
            init_cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
`else
            state_r     <= ST_IDLE;
`endif
            req_we_r     <= 1'b0;
            req_addr_r   <= {ADDR_WIDTH{1'b0}};
            req_wdata_r  <= {DATA_WIDTH{1'b0}};
            req_be_r     <= {BE_WIDTH{1'b0}};
            ready_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rd_r     <= 1'b0;
            sram_req_r   <= 1'b0;
            sram_we_r    <= 1'b0;
            sram_addr_r  <= {ADDR_WIDTH{1'b0}};
            sram_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
`ifdef SRAM_RMW_INIT_EN
            init_done_r <= init_done_s;
            init_cnt_r  <= init_cnt_s;
`endif
            state_r      <= state_s;
            ready_r      <= ready_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_rd_r     <= rsp_rd_s;
            sram_req_r   <= sram_req_s;
            sram_we_r    <= sram_we_s;
            sram_addr_r  <= sram_addr_s;
            sram_wdata_r <= sram_wdata_s;
            if (accept_s) begin
                req_we_r    <= req_we_i;
                req_addr_r  <= req_addr_i;
                req_wdata_r <= req_wdata_i;
                req_be_r    <= req_be_i;
            end else begin
                req_we_r    <= req_we_r;
                req_addr_r  <= req_addr_r;
                req_wdata_r <= req_wdata_r;
                req_be_r    <= req_be_r;
            end
        end
    end

    assign req_ready_o  = ready_r;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_rdata_o  = (rsp_valid_r && rsp_rd_r) ? sram_rdata_i : {DATA_WIDTH{1'b0}};
    assign sram_req_o   = sram_req_r;
    assign sram_we_o    = sram_we_r;
    assign sram_addr_o  = sram_addr_r;
    assign sram_wdata_o = sram_wdata_r;
`ifdef SRAM_RMW_INIT_EN
    assign init_done_o  = init_done_r;
`else
    assign init_done_o  = 1'b1;
`endif

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Bench for sram_rmw_ctrl (default build): behavioural SRAM plus a word-level
// reference memory; per-cycle expectations derived from the transaction kind.
module tb_sram_rmw_ctrl;
    localparam int DW = 32;
    localparam int NW = 256;
    localparam int AW = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [BW-1:0] req_be_i = '0;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [DW-1:0] sram_rdata_i;
    logic          init_done_o;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sram_rmw_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i), .init_done_o(init_done_o)
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    logic [DW-1:0] sram_mem [NW];
    logic [DW-1:0] sram_rd_q = '0;
    logic          preload = 1'b0;
    int unsigned   mem_seed = 32'd0;

    function automatic logic [DW-1:0] pattern(input int i);
        return (32'(i) * 32'h9E3779B1) ^ mem_seed;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) sram_mem[i] <= pattern(i);
        end else if (sram_req_o) begin
            if (sram_we_o) sram_mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rd_q <= sram_mem[sram_addr_o];
        end
    end
    assign sram_rdata_i = sram_rd_q;

    logic [DW-1:0] ref_mem [NW];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sram_req"}, 32'(sram_req_o), 32'd0);
        check({tag, "_sram_we"}, 32'(sram_we_o), 32'd0);
        check({tag, "_sram_addr"}, 32'(sram_addr_o), 32'd0);
        check({tag, "_sram_wdata"}, sram_wdata_o, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_ready"}, 32'(req_ready_o), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(req_ready_o), 32'd1);
    endtask

    task automatic drive_req(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_we_i    = 1'($urandom);
        req_addr_i  = AW'($urandom);
        req_wdata_i = $urandom;
        req_be_i    = BW'($urandom);
    endtask

    // One transaction: accept at edge N, then check cycles N+1..N+4.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        logic [DW-1:0] old_word, new_word;
        logic          exp_req, exp_we;
        logic [DW-1:0] exp_wdata, exp_rdata;
        int            rsp_c;
        bit            partial;
        old_word = ref_mem[addr];
        for (int k = 0; k < BW; k++)
            new_word[8*k +: 8] = be[k] ? wdata[8*k +: 8] : old_word[8*k +: 8];
        partial = we && (be != 4'hF) && (be != 4'h0);
        if (!we)         rsp_c = 2;
        else if (partial) rsp_c = 3;
        else             rsp_c = 1;
        wait_ready();
        drive_req(we, addr, wdata, be);
        for (int c = 1; c <= 4; c++) begin
            exp_req = 1'b0;
            exp_we = 1'b0;
            exp_wdata = '0;
            if (c == 1 && (!we || partial)) exp_req = 1'b1;
            if (c == 1 && we && be == 4'hF) begin
                exp_req = 1'b1; exp_we = 1'b1; exp_wdata = wdata;
            end
            if (c == 3 && partial) begin
                exp_req = 1'b1; exp_we = 1'b1; exp_wdata = new_word;
            end
            check($sformatf("sram_req_c%0d", c), 32'(sram_req_o), 32'(exp_req));
            if (exp_req) begin
                check($sformatf("sram_we_c%0d", c), 32'(sram_we_o), 32'(exp_we));
                check($sformatf("sram_addr_c%0d", c), 32'(sram_addr_o), 32'(addr));
                if (exp_we) check($sformatf("sram_wdata_c%0d", c), sram_wdata_o, exp_wdata);
            end
            exp_rdata = (c == rsp_c && !we) ? old_word : 32'd0;
            check($sformatf("rsp_valid_c%0d", c), 32'(rsp_valid_o), 32'(c == rsp_c));
            check($sformatf("rsp_rdata_c%0d", c), rsp_rdata_o, exp_rdata);
            if (c <= rsp_c) check($sformatf("ready_low_c%0d", c), 32'(req_ready_o), 32'd0);
            if (c < 4) @(negedge clk);
        end
        if (we) ref_mem[addr] = new_word;
    endtask

    initial begin
        logic          r_we;
        logic [AW-1:0] r_addr;
        logic [BW-1:0] r_be;
        int            sel;

        mem_seed = $urandom;
        for (int i = 0; i < NW; i++) ref_mem[i] = pattern(i);
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_init_done", 32'(init_done_o), 32'd1);
        rst_i = 1'b0;

        // Directed scenarios
        run_txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        run_txn(1'b0, 8'h10, 32'h0, 4'h0);
        run_txn(1'b1, 8'h10, 32'h00001122, 4'h3);
        run_txn(1'b0, 8'h10, 32'h0, 4'hF);
        run_txn(1'b1, 8'h10, 32'hFFFFFFFF, 4'h0);
        run_txn(1'b0, 8'h10, 32'h0, 4'h0);
        run_txn(1'b1, 8'hFF, 32'hA5A5_5A5A, 4'h9);
        run_txn(1'b0, 8'hFF, 32'h0, 4'h0);

        // Reset asserted in the MERGE cycle of a partial write
        wait_ready();
        drive_req(1'b1, 8'h20, 32'h12345678, 4'h6);
        check("abort_rd_req", 32'(sram_req_o), 32'd1);
        check("abort_rd_we", 32'(sram_we_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        check("abort_merge_req", 32'(sram_req_o), 32'd0);
        check("abort_merge_rsp", 32'(rsp_valid_o), 32'd0);
        @(negedge clk);
        check_reset_outputs("abort");
        rst_i = 1'b0;
        run_txn(1'b0, 8'h20, 32'h0, 4'h0);

        // Randomized traffic on a small address window
        for (int t = 0; t < 80; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = AW'($urandom_range(0, 7));
            sel    = int'($urandom_range(0, 3));
            if (sel == 0)      r_be = 4'h0;
            else if (sel == 1) r_be = 4'hF;
            else               r_be = BW'($urandom);
            run_txn(r_we, r_addr, $urandom, r_be);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
